sync_fifo_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's fixed 4-entry buffer.
- Generalised in depth and width. Adds fill count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages in the same clock domain.
- First-word-fall-through: the head entry is always visible on data_out.

---
 rtl/sync_fifo_param.sv | 101 ++++++++++
 tb/tb_sync_fifo_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through output.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   push, pop            : write / read requests (pop consumes data_out)
//   flush                : synchronous clear of pointers (storage untouched)
//   err_clr              : synchronous clear of sticky overflow/underflow
//   data_in, data_out    : write data / head entry (zero-latency view)
//   fifo_full/empty      : occupancy == FIFO_DEPTH / == 0
//   almost_full/empty    : occupancy >= AF_LEVEL / <= AE_LEVEL
//   fill_count           : occupancy 0..FIFO_DEPTH
//   overflow, underflow  : sticky error flags
module sync_fifo_param #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic                          err_clr,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic wr_en;
  logic rd_en;
  logic ovf_set;
  logic udf_set;

  // Occupancy and flags derived from the registered pointers.
  always_comb begin
    fifo_empty   = (wr_ptr == rd_ptr);
    fifo_full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    fill_count   = wr_ptr - rd_ptr;
    almost_full  = (fill_count >= PTR_W'(AF_LEVEL));
    almost_empty = (fill_count <= PTR_W'(AE_LEVEL));
    data_out     = mem[rd_ptr[ADDR_W-1:0]];
  end

  // Acceptance; a pop frees a slot so a push is taken even when full.
  // Flush masks both requests and any error they would raise.
  always_comb begin
    wr_en   = push & (~fifo_full | pop) & ~flush;
    rd_en   = pop & ~fifo_empty & ~flush;
    ovf_set = push & fifo_full & ~pop & ~flush;
    udf_set = pop & fifo_empty & ~flush;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage; cleared on reset so data_out reads 0 afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end
  end

  // Sticky errors; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= udf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        push, pop, flush, err_clr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0]  fill_count;
  logic        overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of live entries plus sticky flags.
  logic [31:0] q[$];
  logic        m_ov, m_un;

  typedef struct {
    logic        push;
    logic        pop;
    logic        err_clr;
    logic [31:0] din;
    int          cnt;
    logic        full;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
    logic        chk_head;
    logic [31:0] head;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_param #(
    .FIFO_DEPTH(8), .FIFO_WIDTH(32), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .data_in(data_in), .data_out(data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic p, input logic o, input logic e,
                              input logic [31:0] d, input int cnt,
                              input logic ov, input logic un,
                              input logic ch, input logic [31:0] head);
    vec_t v;
    v.push = p; v.pop = o; v.err_clr = e; v.din = d; v.cnt = cnt;
    v.full = (cnt == DEPTH); v.af = (cnt >= AF); v.ae = (cnt <= AE);
    v.ov = ov; v.un = un; v.chk_head = ch; v.head = head;
    return v;
  endfunction

  task automatic model_step(input logic p, input logic o, input logic f,
                            input logic e, input logic [31:0] d);
    logic was_full, was_empty, ov_set, un_set;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    ov_set    = p && was_full && !o && !f;
    un_set    = o && was_empty && !f;
    if (f) begin
      q.delete();
    end else begin
      if (o && !was_empty) void'(q.pop_front());
      if (p && (!was_full || o)) q.push_back(d);
    end
    m_ov = ov_set | (m_ov & !e);
    m_un = un_set | (m_un & !e);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " count"}, 32'(fill_count), 32'(q.size()));
    chk({tag, " full"},  32'(fifo_full),  32'(q.size() == DEPTH));
    chk({tag, " empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, " afull"}, 32'(almost_full),  32'(q.size() >= AF));
    chk({tag, " aempty"},32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, " ovf"},   32'(overflow),  32'(m_ov));
    chk({tag, " udf"},   32'(underflow), 32'(m_un));
    if (q.size() != 0) chk({tag, " head"}, data_out, q[0]);
  endtask

  // Drive one cycle at negedge, advance the model at posedge, sample #1 later.
  task automatic step(input logic p, input logic o, input logic f,
                      input logic e, input logic [31:0] d);
    @(negedge clk);
    push = p; pop = o; flush = f; err_clr = e; data_in = d;
    @(posedge clk);
    model_step(p, o, f, e, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    push = 0; pop = 0; flush = 0; err_clr = 0; data_in = '0;
    #1;
    q.delete(); m_ov = 0; m_un = 0;
    chk("rst empty", 32'(fifo_empty), 32'd1);
    chk("rst count", 32'(fill_count), 32'd0);
    chk("rst dout",  data_out, 32'd0);
    chk("rst ovf",   32'(overflow), 32'd0);
    chk("rst udf",   32'(underflow), 32'd0);
    chk("rst aempty",32'(almost_empty), 32'd1);
    chk("rst afull", 32'(almost_full), 32'd0);
    chk("rst full",  32'(fifo_full), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    push = 0; pop = 0; flush = 0; err_clr = 0; data_in = '0;
    q.delete(); m_ov = 0; m_un = 0;

    // Directed table: first push, fill, overflow, full push+pop, drain, empty push+pop.
    vecs.push_back(mk(1, 0, 0, 32'hA5A5_0001, 1, 0, 0, 1, 32'hA5A5_0001));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 0, 32'h100 + 32'(i), i + 1, 0, 0, 1, 32'h100));
    vecs.push_back(mk(1, 0, 0, 32'hDEAD, 8, 1, 0, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 32'h0,    8, 1, 0, 1, 32'h100));
    vecs.push_back(mk(0, 0, 1, 32'h0,    8, 0, 0, 1, 32'h100));
    vecs.push_back(mk(1, 1, 0, 32'h200,  8, 0, 0, 1, 32'h101));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(0, 1, 0, 32'h0, 8 - k, 0, 0, 1,
                        (k < 7) ? 32'h101 + 32'(k) : 32'h200));
    vecs.push_back(mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h55, 1, 0, 1, 1, 32'h55));
    vecs.push_back(mk(0, 0, 1, 32'h0,  1, 0, 0, 1, 32'h55));
    vecs.push_back(mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 32'h0));

    repeat (2) @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].push, vecs[i].pop, 1'b0, vecs[i].err_clr, vecs[i].din);
      chk({t, " count"}, 32'(fill_count), 32'(vecs[i].cnt));
      chk({t, " full"},  32'(fifo_full),  32'(vecs[i].full));
      chk({t, " afull"}, 32'(almost_full), 32'(vecs[i].af));
      chk({t, " aempty"},32'(almost_empty), 32'(vecs[i].ae));
      chk({t, " ovf"},   32'(overflow),  32'(vecs[i].ov));
      chk({t, " udf"},   32'(underflow), 32'(vecs[i].un));
      if (vecs[i].chk_head) chk({t, " head"}, data_out, vecs[i].head);
      compare_model(t);
    end

    // Reset mid-stream with errors pending; first push after lands in entry 0.
    step(1, 0, 0, 0, 32'h1111);
    step(1, 0, 0, 0, 32'h2222);
    step(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 32'h3000 + 32'(i));
    chk("pre-rst ovf", 32'(overflow), 32'd1);
    do_reset();
    step(1, 0, 0, 0, 32'hA5A5_0001);
    chk("post-rst dout",  data_out, 32'hA5A5_0001);
    chk("post-rst count", 32'(fill_count), 32'd1);
    compare_model("post-rst");

    // Random traffic across the pointer wrap, checked against the model.
    for (int c = 0; c < 300; c++) begin
      logic p, o, f, e;
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 19) == 0);
      step(p, o, f, e, $urandom);
      compare_model($sformatf("rnd%0d", c));
    end

    // Flush with push: nothing accepted, sticky errors retained.
    step(0, 0, 1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    chk("fl udf set", 32'(underflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h4000 + 32'(i));
    step(1, 0, 1, 0, 32'hBEEF);
    chk("fl empty", 32'(fifo_empty), 32'd1);
    chk("fl count", 32'(fill_count), 32'd0);
    chk("fl udf",   32'(underflow), 32'd1);
    compare_model("flush");
    step(1, 0, 0, 0, 32'h7777);
    chk("fl next head", data_out, 32'h7777);
    compare_model("after-flush");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
